// File: rtl/trb_capture_ctrl_pkg.sv
// Shared types and default widths for the trace-buffer capture controller.
package trb_capture_ctrl_pkg;

   localparam int TRB_ADDR_WIDTH = 8;
   localparam int TRB_WIDTH      = 16;
   localparam int TRB_FILL_WIDTH = TRB_ADDR_WIDTH + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRE   = 2'd1,
      POST  = 2'd2,
      DRAIN = 2'd3
   } trb_state_t;

endpackage

// File: rtl/trb_capture_ctrl_drain_skid.sv
// Two-entry valid/ready skid buffer behind the BRAM read port. The credit
// output tells the read issuer whether another read fits, counting the
// entry leaving this cycle so a continuous stream runs at full rate.
module trb_drain_skid #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              in_flight,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              credit
);

   logic [DATA_W-1:0] skid_p2 [2];
   logic [1:0]        cnt;
   logic              wr_idx;
   logic              rd_idx;
   logic              pop;
   logic [2:0]        occ;

   // Head of the buffer drives the stream; occupancy after this cycle's pop gates new reads
   always_comb begin
      out_valid = (cnt != 2'd0);
      out_data  = out_valid ? skid_p2[rd_idx] : '0;
      pop       = out_valid & out_ready;
      occ       = {1'b0, cnt} - {2'b00, pop} + {2'b00, in_flight};
      credit    = (occ < 3'd2);
   end

   // Occupancy and ring indices; flush drops everything buffered
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         cnt    <= 2'd0;
         wr_idx <= 1'b0;
         rd_idx <= 1'b0;
      end else begin
         if (push) wr_idx <= ~wr_idx;
         if (pop)  rd_idx <= ~rd_idx;
         cnt <= cnt + {1'b0, push} - {1'b0, pop};
      end
   end

   // --- stage p2: BRAM read data lands in the skid entries ---
   always_ff @(posedge clk) begin
      if (push) skid_p2[wr_idx] <= push_data;
   end

endmodule

// File: rtl/trb_capture_ctrl.sv
// Trace-buffer sequencer: arms, captures a circular pre/post-trigger window
// into a write-every-cycle BRAM, then drains it oldest-first as a stream.
module trb_capture_ctrl
   import trb_capture_ctrl_pkg::*;
#(
   parameter int ADDR_W = TRB_ADDR_WIDTH,
   parameter int DATA_W = TRB_WIDTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_arm,
   input  logic              cfg_abort,
   input  logic [ADDR_W-1:0] cfg_post_cnt,
   input  logic              trace_valid,
   input  logic [DATA_W-1:0] trace_data,
   input  logic              trace_trig,
   output logic [ADDR_W-1:0] bram_wr_addr,
   output logic [DATA_W-1:0] bram_wr_data,
   output logic [ADDR_W-1:0] bram_rd_addr,
   input  logic [DATA_W-1:0] bram_rd_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic              out_last,
   output logic [1:0]        stat_state,
   output logic [ADDR_W-1:0] stat_trig_addr,
   output logic              stat_done
);

   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   FILL_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   DEPTH_F  = FILL_ONE << ADDR_W;

   trb_state_t        state, state_nxt;
   logic [ADDR_W-1:0] wr_ptr, wr_ptr_inc, rd_ptr, post_left;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [DATA_W-1:0] wr_data_q;
   logic [ADDR_W:0]   fill, fill_inc, reads_left, beats_left;
   logic              wr_en, trig_hit, post_done, issue, hs, credit;
   logic              vld_p1;

   // Next state, write-port mux (hold last write when idle) and drain handshake decode
   always_comb begin
      state_nxt    = state;
      wr_en        = ((state == PRE) || (state == POST)) && trace_valid;
      trig_hit     = (state == PRE) && trace_valid && trace_trig;
      post_done    = (state == POST) && trace_valid && (post_left == PTR_ONE);
      wr_ptr_inc   = wr_ptr + PTR_ONE;
      fill_inc     = (fill == DEPTH_F) ? fill : fill + FILL_ONE;
      hs           = out_valid && out_ready;
      out_last     = out_valid && (beats_left == FILL_ONE);
      stat_done    = hs && out_last;
      issue        = (state == DRAIN) && (reads_left != '0) && credit && !cfg_abort;
      bram_wr_addr = wr_en ? wr_ptr : wr_addr_q;
      bram_wr_data = wr_en ? trace_data : wr_data_q;
      bram_rd_addr = rd_ptr;
      stat_state   = state;
      case (state)
         IDLE:    if (cfg_arm) state_nxt = PRE;
         PRE:     if (trig_hit) state_nxt = (post_left == '0) ? DRAIN : POST;
         POST:    if (post_done) state_nxt = DRAIN;
         DRAIN:   if (stat_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (cfg_abort) state_nxt = IDLE;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // --- stage p0: capture pointers, trigger latch and read issue ---
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr         <= '0;
         fill           <= '0;
         post_left      <= '0;
         wr_addr_q      <= '0;
         wr_data_q      <= '0;
         stat_trig_addr <= '0;
         rd_ptr         <= '0;
         reads_left     <= '0;
         beats_left     <= '0;
         vld_p1         <= 1'b0;
      end else begin
         if ((state == IDLE) && cfg_arm && !cfg_abort) begin
            wr_ptr    <= '0;
            fill      <= '0;
            post_left <= cfg_post_cnt;
         end
         if (wr_en) begin
            wr_ptr    <= wr_ptr_inc;
            fill      <= fill_inc;
            wr_addr_q <= wr_ptr;
            wr_data_q <= trace_data;
         end
         if (trig_hit) stat_trig_addr <= wr_ptr;
         if ((state == POST) && trace_valid) post_left <= post_left - PTR_ONE;
         // Window start is computed from the pointer/fill values this final write produces
         if ((state != DRAIN) && (state_nxt == DRAIN)) begin
            rd_ptr     <= wr_ptr_inc - fill_inc[ADDR_W-1:0];
            reads_left <= fill_inc;
            beats_left <= fill_inc;
         end
         if (issue) begin
            rd_ptr     <= rd_ptr + PTR_ONE;
            reads_left <= reads_left - FILL_ONE;
         end
         if (hs) beats_left <= beats_left - FILL_ONE;
         vld_p1 <= issue;
      end
   end

   // --- stage p1: BRAM read data returns one cycle after issue ---
   trb_drain_skid #(.DATA_W(DATA_W)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (cfg_abort),
      .push      (vld_p1),
      .push_data (bram_rd_data),
      .in_flight (vld_p1),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .credit    (credit)
   );

endmodule

// File: tb/tb_trb_capture_ctrl.sv
// Bench for trb_capture_ctrl with an attached write-every-cycle BRAM model.
module tb_trb_capture_ctrl;
   import trb_capture_ctrl_pkg::*;

   localparam int AW    = 8;
   localparam int DW    = 16;
   localparam int DEPTH = 256;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_arm, cfg_abort;
   logic [AW-1:0] cfg_post_cnt;
   logic          trace_valid, trace_trig;
   logic [DW-1:0] trace_data;
   logic [AW-1:0] bram_wr_addr, bram_rd_addr, stat_trig_addr;
   logic [DW-1:0] bram_wr_data, bram_rd_data, out_data;
   logic          out_valid, out_ready, out_last, stat_done;
   logic [1:0]    stat_state;

   trb_capture_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk            (clk),
      .rst            (rst),
      .cfg_arm        (cfg_arm),
      .cfg_abort      (cfg_abort),
      .cfg_post_cnt   (cfg_post_cnt),
      .trace_valid    (trace_valid),
      .trace_data     (trace_data),
      .trace_trig     (trace_trig),
      .bram_wr_addr   (bram_wr_addr),
      .bram_wr_data   (bram_wr_data),
      .bram_rd_addr   (bram_rd_addr),
      .bram_rd_data   (bram_rd_data),
      .out_valid      (out_valid),
      .out_data       (out_data),
      .out_ready      (out_ready),
      .out_last       (out_last),
      .stat_state     (stat_state),
      .stat_trig_addr (stat_trig_addr),
      .stat_done      (stat_done)
   );

   always #5 clk = ~clk;

   // BRAM model: writes every clock, registered read
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) begin
      mem[bram_wr_addr] <= bram_wr_data;
      bram_rd_data      <= mem[bram_rd_addr];
   end

   int            n_cmp = 0;
   int            n_err = 0;
   int            done_cnt = 0;
   int            beat_cnt = 0;
   int            rdy_mode = 0;
   int            rdy_idx = 0;
   beat_t         exp_q[$];
   logic [DW-1:0] model_q[$];
   logic [DW-1:0] snap [DEPTH];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (rdy_mode == 0) out_ready = 1'b1;
      else begin
         if (rdy_idx < 4) out_ready = (rdy_idx == 0) || (rdy_idx == 3);
         else             out_ready = 1'($urandom_range(0, 1));
         rdy_idx++;
      end
   endtask

   // Stream monitor: scoreboard pop, last/done check, stall stability
   beat_t         mon_b;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data  = '0;
   logic          prev_last  = 1'b0;
   always @(negedge clk) begin
      if (!rst) begin
         if (prev_stall) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'(prev_data));
            chk("stall_last", 32'(out_last), 32'(prev_last));
         end
         if (out_valid && out_ready) begin
            beat_cnt++;
            if (stat_done) done_cnt++;
            if (exp_q.size() == 0) chk("extra_beat", 32'(out_data), 32'hFFFF_FFFF);
            else begin
               mon_b = exp_q.pop_front();
               chk("beat_data", 32'(out_data), 32'(mon_b.data));
               chk("beat_last", 32'(out_last), 32'(mon_b.last));
               chk("beat_done", 32'(stat_done), 32'(mon_b.last));
            end
         end else if (stat_done) begin
            chk("done_without_hs", 32'(stat_done), 32'd0);
         end
         prev_stall = out_valid && !out_ready && !cfg_abort;
         prev_data  = out_data;
         prev_last  = out_last;
      end
   end

   task automatic run_capture(input int post, input int n, input int trig_at,
                              input int base, input int gap_at);
      int first;
      model_q.delete();
      cfg_post_cnt = AW'(post);
      cfg_arm      = 1'b1;
      trace_valid  = 1'b1;
      trace_trig   = 1'b1;
      trace_data   = '1;
      step();
      cfg_arm     = 1'b0;
      trace_valid = 1'b0;
      trace_trig  = 1'b0;
      chk("arm_to_pre", 32'(stat_state), 32'd1);
      for (int i = 0; i < n; i++) begin
         if (i == gap_at) begin
            trace_valid = 1'b0;
            trace_trig  = 1'b1;
            trace_data  = 16'hBEEF;
            step();
         end
         trace_valid = 1'b1;
         trace_data  = DW'(base + i);
         trace_trig  = (i == trig_at);
         model_q.push_back(DW'(base + i));
         step();
      end
      trace_valid = 1'b0;
      trace_trig  = 1'b0;
      first = (model_q.size() > DEPTH) ? model_q.size() - DEPTH : 0;
      for (int i = first; i < model_q.size(); i++)
         exp_q.push_back('{data: model_q[i], last: (i == model_q.size() - 1)});
   endtask

   task automatic wait_drain(input int exp_trig, input int done_before);
      int cyc = 0;
      while (exp_q.size() != 0 && cyc < 3000) begin
         step();
         cyc++;
      end
      chk("drain_left", 32'(exp_q.size()), 32'd0);
      step();
      step();
      chk("trig_addr", 32'(stat_trig_addr), 32'(exp_trig));
      chk("done_count", 32'(done_cnt - done_before), 32'd1);
      chk("idle_after_drain", 32'(stat_state), 32'd0);
      chk("valid_after_drain", 32'(out_valid), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      int d0, b0, cyc, diffs;
      logic [AW-1:0] hold_addr;
      logic [DW-1:0] hold_data;
      for (int i = 0; i < DEPTH; i++) mem[i] = 16'hDEAD;
      rst = 1'b1; cfg_arm = 1'b0; cfg_abort = 1'b0; cfg_post_cnt = '0;
      trace_valid = 1'b0; trace_trig = 1'b0; trace_data = '0; out_ready = 1'b1;
      step(); step(); step();
      rst = 1'b0;
      chk("rst_state", 32'(stat_state), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_wr_addr", 32'(bram_wr_addr), 32'd0);
      chk("rst_wr_data", 32'(bram_wr_data), 32'd0);
      chk("rst_rd_addr", 32'(bram_rd_addr), 32'd0);
      chk("rst_trig_addr", 32'(stat_trig_addr), 32'd0);
      chk("rst_done", 32'(stat_done), 32'd0);

      // abort wins over arm in IDLE
      cfg_arm = 1'b1; cfg_abort = 1'b1;
      step();
      cfg_arm = 1'b0; cfg_abort = 1'b0;
      chk("arm_abort_idle", 32'(stat_state), 32'd0);

      // basic window: post=4, trigger on sample 5
      d0 = done_cnt;
      run_capture(4, 10, 5, 0, -1);
      chk("t1_drain_state", 32'(stat_state), 32'd3);
      chk("t1_start_addr", 32'(bram_rd_addr), 32'd0);
      wait_drain(5, d0);

      // wrapped full buffer, post=0, trigger on the final sample
      d0 = done_cnt;
      run_capture(0, 300, 299, 0, -1);
      chk("t2_drain_state", 32'(stat_state), 32'd3);
      chk("t2_start_addr", 32'(bram_rd_addr), 32'd44);
      wait_drain(43, d0);

      // trigger with valid low is ignored; arm-cycle trigger is ignored
      d0 = done_cnt;
      run_capture(3, 11, 7, 100, 3);
      wait_drain(7, d0);

      // backpressure: ready 1,0,0,1 then random
      d0 = done_cnt;
      run_capture(5, 40, 34, 200, -1);
      rdy_mode = 1; rdy_idx = 0;
      wait_drain(34, d0);
      rdy_mode = 0;

      // idle rewrites must not disturb the captured contents
      step();
      for (int i = 0; i < DEPTH; i++) snap[i] = mem[i];
      hold_addr = bram_wr_addr;
      hold_data = bram_wr_data;
      for (int i = 0; i < 20; i++) begin
         trace_valid = 1'($urandom_range(0, 1));
         trace_trig  = 1'($urandom_range(0, 1));
         trace_data  = DW'($urandom);
         step();
      end
      trace_valid = 1'b0; trace_trig = 1'b0;
      diffs = 0;
      for (int i = 0; i < DEPTH; i++) if (mem[i] !== snap[i]) diffs++;
      chk("idle_mem_diffs", 32'(diffs), 32'd0);
      chk("idle_wr_addr", 32'(bram_wr_addr), 32'(hold_addr));
      chk("idle_wr_data", 32'(bram_wr_data), 32'(hold_data));
      chk("idle_state", 32'(stat_state), 32'd0);

      // abort three beats into DRAIN, then a clean re-arm
      d0 = done_cnt;
      run_capture(2, 20, 17, 500, -1);
      b0 = beat_cnt;
      cyc = 0;
      while ((beat_cnt - b0) < 3 && cyc < 200) begin
         step();
         cyc++;
      end
      chk("abort_reach_beats", 32'((beat_cnt - b0) >= 3), 32'd1);
      cfg_abort = 1'b1;
      step();
      cfg_abort = 1'b0;
      chk("abort_valid_drop", 32'(out_valid), 32'd0);
      chk("abort_state", 32'(stat_state), 32'd0);
      exp_q.delete();
      step(); step(); step();
      chk("abort_valid_stays", 32'(out_valid), 32'd0);
      chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
      d0 = done_cnt;
      run_capture(2, 12, 9, 1000, -1);
      wait_drain(9, d0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_err);
      $fatal(1, "watchdog expired");
   end

endmodule
